kid_ctrl: RTL and testbench
===========================

# kid_ctrl

Player-character controller for the trap-game datapath. It turns keyboard levels into the kid's on-screen position, which every trap and hazard consumes as `kid_x`/`kid_y`. It also aggregates their `is_collide` returns into a death/respawn state machine and drives the shared trap reset that re-arms falling traps. It sits between the keyboard decoder and the trap instances, single clock domain, advancing physics once per frame tick.

## Interface
- `spawn_x`, default 40: respawn/reset x (hitbox centre, pixels)
- `floor_y`, default 560: standing y (hitbox centre); also spawn y
- `x_min`, default 8: left clamp, inclusive
- `x_max`, default 791: right clamp, inclusive
- `walk_v`, default 3: horizontal pixels per tick
- `jump_v`, default 8: first-jump launch speed
- `djump_v`, default 7: double-jump launch speed
- `grav`, default 1: vy increment per tick
- `max_fall`, default 9: vy positive clamp
- `clk` in 1: system clock
- `rst_n` in 1: synchronous, active-low reset
- `update_tick` in 1: one-`clk` frame strobe; physics advances only on it
- `key_left`, `key_right`, `key_jump`, `key_restart` in 1 each: key levels, already synchronised
- `is_collide` in 1: OR of all hazard collide outputs
- `kid_x`, `kid_y` out 10: hitbox centre; reset `spawn_x`/`floor_y`
- `kid_dir` out 1: 0 right, 1 left; reset 0
- `kid_state` out 2: GROUND/AIR/DEAD/RESPAWN encoding; reset GROUND
- `is_dead` out 1: high in DEAD; reset 0
- `trap_rst` out 1: active-high reset to traps; reset value 1
- `death_count` out 10: saturating at 1023; reset 0

## Operation
- States: GROUND, AIR, DEAD, RESPAWN.
- Rising edges of `key_jump`/`key_restart` are detected every `clk` and latched as pending flags. Flags clear on the consuming tick.
- Per tick in GROUND/AIR, in this order:
  - Horizontal: left XOR right moves by ∓`walk_v`; both or neither means no move. The result is clamped to [`x_min`,`x_max`]. `kid_dir` follows the last single key pressed.
  - Jump pending: in GROUND, vy=-`jump_v`, djump_avail=1, go to AIR. In AIR with djump_avail, vy=-`djump_v`, djump_avail=0. Otherwise the pending jump is discarded.
  - Vertical: y_new = y + vy, computed in 11-bit signed.
    - If y_new ≥ `floor_y`: y=`floor_y`, vy=0, go to GROUND.
    - If y_new < 0: y=0, vy=0.
    - Otherwise: y=y_new, then vy=min(vy+`grav`, `max_fall`).
  - vy is 6-bit signed.
- Death: `is_collide` is sampled every `clk`, not only on ticks. While in GROUND/AIR it moves to DEAD the next cycle, sets `is_dead`, and increments `death_count` (saturating). Position freezes. Collide is ignored in DEAD/RESPAWN.
- Restart: a pending restart in any state moves to RESPAWN at the next `clk`. The position is set to spawn and vy=0.
  - `trap_rst`=1 throughout RESPAWN.
  - RESPAWN exits to GROUND on the `clk` after the next `update_tick`, so traps see reset asserted across one tick.
  - `is_dead` clears on entry to RESPAWN.
- Collide and restart in the same cycle while alive: death wins; the restart stays pending and is taken next cycle.
- After reset, `trap_rst` stays high until the first `update_tick`, then clears.

## Timing
- Key edge to effect: up to one frame. The effect applies on the tick strobe cycle and is visible the following `clk`.
- Collide to `is_dead`: 1 `clk`.
- All outputs are registered.
- `rst_n` low mid-jump or mid-death on any edge:
  - All state returns to reset values.
  - Pending flags clear.
  - `death_count` clears.

## Structure
- Package `kid_pkg` holds:
  - the state enum;
  - `SCREEN_W`=800 and `SCREEN_H`=600;
  - the 6-bit velocity type.
- Sub-module `key_edge_latch`: a registered previous-value edge detector plus a pending flag that sets on edge and clears on a `consume` input. Two instances: jump and restart.

## Test plan
- Reset then jump edge, no other keys, run 40 ticks. Required:
  - first tick: y 560→552;
  - peak y=524;
  - returns to 560 in GROUND with vy=0.
- Jump, then a second jump edge at vy=-5 (y=539), with key_right held:
  - second launch gives vy=-7 and y=532 on that tick;
  - a third edge is ignored;
  - x advances by 3 per tick.
- key_left held 20 ticks from x=40: x reaches 8 and stays; `kid_dir`=1.
- Pulse `is_collide` for 1 `clk` mid-air at y=530:
  - `is_dead`=1 next cycle, `death_count`=1, position frozen;
  - a second collide does not increment the count.
- In DEAD, `key_restart` edge:
  - RESPAWN with `trap_rst`=1, held through one `update_tick`;
  - then GROUND at (40,560) with `trap_rst`=0.
- `is_collide` and restart edge in the same cycle while alive: DEAD for 1 cycle, `death_count`+1, then RESPAWN. Also: drop `rst_n` during RESPAWN; all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/kid_pkg.sv
// Shared types and screen constants for the player-character controller.
package kid_pkg;

  localparam int SCREEN_W = 800;
  localparam int SCREEN_H = 600;

  typedef enum logic [1:0] {
    ST_GROUND  = 2'd0,
    ST_AIR     = 2'd1,
    ST_DEAD    = 2'd2,
    ST_RESPAWN = 2'd3
  } kid_state_e;

  typedef logic signed [5:0] vel_t;

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/kid_ctrl_if.sv
// Keyboard/hazard inputs and kid position/status outputs of the controller.
// master is the controller itself; slave is the keyboard and trap side.
interface kid_ctrl_if;
  import kid_pkg::*;

  logic       update_tick;
  logic       key_left;
  logic       key_right;
  logic       key_jump;
  logic       key_restart;
  logic       is_collide;
  logic [9:0] kid_x;
  logic [9:0] kid_y;
  logic       kid_dir;
  kid_state_e kid_state;
  logic       is_dead;
  logic       trap_rst;
  logic [9:0] death_count;

  modport master (
    input  update_tick, key_left, key_right, key_jump, key_restart, is_collide,
    output kid_x, kid_y, kid_dir, kid_state, is_dead, trap_rst, death_count
  );

  modport slave (
    output update_tick, key_left, key_right, key_jump, key_restart, is_collide,
    input  kid_x, kid_y, kid_dir, kid_state, is_dead, trap_rst, death_count
  );

endinterface

// File: rtl/key_edge_latch.sv
// Rising-edge detector with a sticky pending flag cleared by the consumer.
module key_edge_latch (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  input  logic consume,
  output logic pending
);

  logic prev;

  // A new edge on the consuming cycle wins so that press is not lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev    <= 1'b0;
      pending <= 1'b0;
    end else begin
      prev    <= key;
      pending <= (key & ~prev) | (pending & ~consume);
    end
  end

endmodule

// File: rtl/kid_ctrl.sv
// Kid movement physics, death/respawn sequencing and trap reset generation.
//
//   state      | meaning
//   -----------+-----------------------------------------------
//   ST_GROUND  | standing on the floor, physics runs per tick
//   ST_AIR     | airborne, physics runs per tick
//   ST_DEAD    | hit a hazard, position frozen until restart
//   ST_RESPAWN | at spawn, traps held in reset across one tick
module kid_ctrl
  import kid_pkg::*;
#(
  parameter int spawn_x  = 40,
  parameter int floor_y  = SCREEN_H - 40,
  parameter int x_min    = 8,
  parameter int x_max    = SCREEN_W - 9,
  parameter int walk_v   = 3,
  parameter int jump_v   = 8,
  parameter int djump_v  = 7,
  parameter int grav     = 1,
  parameter int max_fall = 9
) (
  input logic        clk,
  input logic        rst_n,
  kid_ctrl_if.master bus
);

  localparam logic [9:0]         SPAWN_X    = 10'(spawn_x);
  localparam logic [9:0]         FLOOR_Y    = 10'(floor_y);
  localparam logic signed [10:0] FLOOR_S    = 11'(floor_y);
  localparam logic signed [11:0] X_LO       = 12'(x_min);
  localparam logic signed [11:0] X_HI       = 12'(x_max);
  localparam logic signed [11:0] WALK       = 12'(walk_v);
  localparam vel_t               JUMP_VY    = 6'(-jump_v);
  localparam vel_t               DJUMP_VY   = 6'(-djump_v);
  localparam logic signed [7:0]  GRAV_V     = 8'(grav);
  localparam logic signed [7:0]  MAX_FALL_V = 8'(max_fall);

  kid_state_e state_q, state_d, st_p;
  logic [9:0] x_q, x_d, x_p;
  logic [9:0] y_q, y_d, y_p;
  logic [9:0] death_q, death_d;
  vel_t       vy_q, vy_d, vy_p, vy_j;
  logic       djump_q, djump_d, dj_p;
  logic       dir_q, dir_d, dir_p;
  logic       dead_q, dead_d;
  logic       trst_q, trst_d;
  logic       jump_pend, restart_pend, restart_take;
  logic       alive;

  logic signed [11:0] x_mv;
  logic signed [10:0] y_new;
  logic signed [7:0]  vy_inc;

  assign alive = (state_q == ST_GROUND) || (state_q == ST_AIR);

  key_edge_latch u_jump (
    .clk     (clk),
    .rst_n   (rst_n),
    .key     (bus.key_jump),
    .consume (bus.update_tick),
    .pending (jump_pend)
  );

  key_edge_latch u_restart (
    .clk     (clk),
    .rst_n   (rst_n),
    .key     (bus.key_restart),
    .consume (restart_take),
    .pending (restart_pend)
  );

  // Candidate result of one physics tick; only committed by the FSM.
  always_comb begin
    x_mv  = $signed({2'b00, x_q});
    dir_p = dir_q;
    if (bus.key_left && !bus.key_right) begin
      x_mv  = x_mv - WALK;
      dir_p = 1'b1;
    end else if (bus.key_right && !bus.key_left) begin
      x_mv  = x_mv + WALK;
      dir_p = 1'b0;
    end
    if (x_mv < X_LO) begin
      x_mv = X_LO;
    end else if (x_mv > X_HI) begin
      x_mv = X_HI;
    end
    x_p = x_mv[9:0];

    vy_j = vy_q;
    dj_p = djump_q;
    st_p = state_q;
    if (jump_pend) begin
      if (state_q == ST_GROUND) begin
        vy_j = JUMP_VY;
        dj_p = 1'b1;
        st_p = ST_AIR;
      end else if (djump_q) begin
        vy_j = DJUMP_VY;
        dj_p = 1'b0;
      end
    end

    y_new  = $signed({1'b0, y_q}) + 11'(vy_j);
    vy_inc = 8'(vy_j) + GRAV_V;
    if (y_new >= FLOOR_S) begin
      y_p  = FLOOR_Y;
      vy_p = '0;
      st_p = ST_GROUND;
    end else if (y_new[10]) begin
      y_p  = '0;
      vy_p = '0;
    end else begin
      y_p  = y_new[9:0];
      vy_p = (vy_inc > MAX_FALL_V) ? MAX_FALL_V[5:0] : vy_inc[5:0];
    end
  end

  // Priority: death while alive, then a pending restart, then the tick.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    vy_d         = vy_q;
    djump_d      = djump_q;
    dir_d        = dir_q;
    death_d      = death_q;
    restart_take = 1'b0;
    if (alive && bus.is_collide) begin
      state_d = ST_DEAD;
      death_d = sat_inc10(death_q);
    end else if (restart_pend) begin
      restart_take = 1'b1;
      state_d      = ST_RESPAWN;
      x_d          = SPAWN_X;
      y_d          = FLOOR_Y;
      vy_d         = '0;
      djump_d      = 1'b0;
    end else if (bus.update_tick) begin
      if (state_q == ST_RESPAWN) begin
        state_d = ST_GROUND;
      end else if (alive) begin
        state_d = st_p;
        x_d     = x_p;
        y_d     = y_p;
        vy_d    = vy_p;
        djump_d = dj_p;
        dir_d   = dir_p;
      end
    end
    dead_d = (state_d == ST_DEAD);
    if (state_d == ST_RESPAWN) begin
      trst_d = 1'b1;
    end else if (bus.update_tick) begin
      trst_d = 1'b0;
    end else begin
      trst_d = trst_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_GROUND;
      x_q     <= SPAWN_X;
      y_q     <= FLOOR_Y;
      vy_q    <= '0;
      djump_q <= 1'b0;
      dir_q   <= 1'b0;
      dead_q  <= 1'b0;
      trst_q  <= 1'b1;
      death_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      vy_q    <= vy_d;
      djump_q <= djump_d;
      dir_q   <= dir_d;
      dead_q  <= dead_d;
      trst_q  <= trst_d;
      death_q <= death_d;
    end
  end

  assign bus.kid_x       = x_q;
  assign bus.kid_y       = y_q;
  assign bus.kid_dir     = dir_q;
  assign bus.kid_state   = state_q;
  assign bus.is_dead     = dead_q;
  assign bus.trap_rst    = trst_q;
  assign bus.death_count = death_q;

endmodule

// File: tb/tb_kid_ctrl.sv
// Scoreboard bench for kid_ctrl: directed scenarios plus random keys/ticks/collides.
module tb_kid_ctrl;
  import kid_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  kid_ctrl_if bus();

  kid_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int    x;
    int    y;
    int    dir;
    int    st;
    int    dead;
    int    trst;
    int    cnt;
    string tag;
  } exp_t;

  exp_t  sb[$];
  int    n_vec = 0;
  int    n_bad = 0;
  string phase = "reset";

  bit s_rst = 0, s_tick = 0, s_left = 0, s_right = 0, s_jump = 0, s_restart = 0, s_col = 0;

  // Reference model state (plain integers, game rules applied directly)
  int m_x = 40, m_y = 560, m_vy = 0, m_cnt = 0, m_st = 0;
  bit m_dj = 0, m_dir = 0, m_dead = 0, m_trst = 1;
  bit m_jp = 0, m_rp = 0, m_pj = 0, m_pr = 0;

  task automatic model_step();
    bit alive, take_r, n_jp, n_rp;
    int ny;
    if (!s_rst) begin
      m_x = 40; m_y = 560; m_vy = 0; m_dj = 0; m_dir = 0; m_st = ST_GROUND;
      m_dead = 0; m_trst = 1; m_cnt = 0; m_jp = 0; m_rp = 0; m_pj = 0; m_pr = 0;
      return;
    end
    alive  = (m_st == ST_GROUND) || (m_st == ST_AIR);
    n_jp   = (s_jump && !m_pj) || (m_jp && !s_tick);
    take_r = m_rp && !(alive && s_col);
    n_rp   = (s_restart && !m_pr) || (m_rp && !take_r);
    if (alive && s_col) begin
      m_st = ST_DEAD;
      if (m_cnt < 1023) m_cnt++;
    end else if (take_r) begin
      m_st = ST_RESPAWN; m_x = 40; m_y = 560; m_vy = 0; m_dj = 0;
    end else if (s_tick) begin
      if (m_st == ST_RESPAWN) begin
        m_st = ST_GROUND;
      end else if (alive) begin
        if (s_left != s_right) begin
          m_x  += s_left ? -3 : 3;
          m_dir = s_left;
        end
        if (m_x < 8) m_x = 8;
        if (m_x > 791) m_x = 791;
        if (m_jp) begin
          if (m_st == ST_GROUND) begin
            m_vy = -8; m_dj = 1; m_st = ST_AIR;
          end else if (m_dj) begin
            m_vy = -7; m_dj = 0;
          end
        end
        ny = m_y + m_vy;
        if (ny >= 560) begin
          m_y = 560; m_vy = 0; m_st = ST_GROUND;
        end else if (ny < 0) begin
          m_y = 0; m_vy = 0;
        end else begin
          m_y  = ny;
          m_vy = (m_vy + 1 > 9) ? 9 : m_vy + 1;
        end
      end
    end
    m_dead = (m_st == ST_DEAD);
    if (m_st == ST_RESPAWN) m_trst = 1;
    else if (s_tick) m_trst = 0;
    m_jp = n_jp; m_rp = n_rp; m_pj = s_jump; m_pr = s_restart;
  endtask

  task automatic cyc();
    exp_t e;
    @(negedge clk);
    rst_n           = s_rst;
    bus.update_tick = s_tick;
    bus.key_left    = s_left;
    bus.key_right   = s_right;
    bus.key_jump    = s_jump;
    bus.key_restart = s_restart;
    bus.is_collide  = s_col;
    model_step();
    e.x = m_x; e.y = m_y; e.dir = int'(m_dir); e.st = m_st;
    e.dead = int'(m_dead); e.trst = int'(m_trst); e.cnt = m_cnt; e.tag = phase;
    sb.push_back(e);
    s_tick = 0;
    s_col  = 0;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      cyc();
      cyc();
      s_tick = 1;
      cyc();
    end
  endtask

  task automatic press_jump();
    s_jump = 1; cyc();
    s_jump = 0; cyc();
  endtask

  task automatic press_restart();
    s_restart = 1; cyc();
    s_restart = 0; cyc();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_vec++;
        if (int'(bus.kid_x) != e.x || int'(bus.kid_y) != e.y || int'(bus.kid_dir) != e.dir ||
            int'(bus.kid_state) != e.st || int'(bus.is_dead) != e.dead ||
            int'(bus.trap_rst) != e.trst || int'(bus.death_count) != e.cnt) begin
          n_bad++;
          $display("FAIL %s @%0t: got x=%0d y=%0d dir=%0d st=%0d dead=%0d trst=%0d cnt=%0d, want x=%0d y=%0d dir=%0d st=%0d dead=%0d trst=%0d cnt=%0d",
                   e.tag, $time, bus.kid_x, bus.kid_y, bus.kid_dir, int'(bus.kid_state),
                   bus.is_dead, bus.trap_rst, bus.death_count,
                   e.x, e.y, e.dir, e.st, e.dead, e.trst, e.cnt);
        end
      end
    end
  end

  initial begin
    bus.update_tick = 0; bus.key_left = 0; bus.key_right = 0;
    bus.key_jump = 0; bus.key_restart = 0; bus.is_collide = 0;

    phase = "reset";
    s_rst = 0;
    repeat (3) cyc();
    s_rst = 1;
    phase = "trap_rst_release";
    frames(2);

    phase = "single_jump";
    press_jump();
    frames(40);

    phase = "double_jump";
    s_right = 1;
    press_jump();
    frames(3);
    press_jump();
    frames(1);
    press_jump();
    frames(30);
    s_right = 0;

    phase = "respawn_to_spawn";
    press_restart();
    frames(2);

    phase = "walk_left_clamp";
    s_left = 1;
    frames(20);
    s_left = 0;

    phase = "collide_mid_air";
    press_jump();
    frames(5);
    s_col = 1; cyc();
    cyc(); cyc();
    s_col = 1; cyc();
    frames(2);

    phase = "restart_from_dead";
    press_restart();
    cyc();
    frames(2);

    phase = "collide_and_restart";
    s_restart = 1; s_col = 1; cyc();
    s_restart = 0;
    cyc(); cyc();

    phase = "reset_in_respawn";
    s_rst = 0; cyc();
    s_rst = 1;
    frames(2);

    phase = "death_saturation";
    for (int i = 0; i < 1030; i++) begin
      s_col = 1; cyc();
      s_restart = 1; cyc();
      s_restart = 0; cyc();
      s_tick = 1; cyc();
    end

    phase = "random";
    for (int i = 0; i < 2000; i++) begin
      s_tick = ($urandom_range(3) == 0);
      if ($urandom_range(7) == 0) s_left  = 1'($urandom_range(1));
      if ($urandom_range(7) == 0) s_right = 1'($urandom_range(1));
      if ($urandom_range(3) == 0) s_jump  = 1'($urandom_range(1));
      s_restart = ($urandom_range(80) == 0);
      s_col     = ($urandom_range(50) == 0);
      s_rst     = ($urandom_range(500) != 0);
      cyc();
    end
    s_rst = 1;
    cyc();

    repeat (3) @(posedge clk);
    #2;
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
